// File: rtl/amo_queue.sv
// amo_queue: in-order AMO buffer that issues one request at a time to the D-cache once the LSQ has drained.
// Optional macro AMO_QUEUE_RESULT_REG_EN registers result_o/result_valid_o one cycle after the ack.
module amo_queue #(
    parameter int DEPTH  = 2,
    parameter int PLEN   = 56,
    parameter int DATA_W = 64,
    parameter int OP_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [OP_W-1:0]   amo_op_i,
    input  logic [PLEN-1:0]   paddr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        data_size_i,
    input  logic              no_mem_ops_pending_i,
    output logic              amo_req_o,
    output logic [OP_W-1:0]   amo_op_o,
    output logic [PLEN-1:0]   amo_addr_o,
    output logic [DATA_W-1:0] amo_data_o,
    output logic [1:0]        amo_size_o,
    input  logic              amo_ack_i,
    input  logic [DATA_W-1:0] amo_result_i,
    output logic              result_valid_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [OP_W-1:0]   op_mem   [DEPTH];
    logic [PLEN-1:0]   addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [1:0]        size_mem [DEPTH];

    logic [PTR_W-1:0] rptr, wptr;
    logic [CNT_W-1:0] count;
    logic             push, pop, issue;

    // Pointers wrap explicitly so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] fmt_result(input logic [DATA_W-1:0] r,
                                                     input logic [1:0]        sz);
        logic signed [31:0] word;
        word = r[31:0];
        case (sz)
            2'd0:    return {{(DATA_W-8){1'b0}}, r[7:0]};
            2'd1:    return {{(DATA_W-16){1'b0}}, r[15:0]};
            2'd2:    return {{(DATA_W-32){word[31]}}, word};
            default: return r;
        endcase
    endfunction

    assign ready_o = (count < CNT_W'(DEPTH)) && !flush_i;
    assign push    = valid_i && ready_o;
    assign pop     = issue && amo_ack_i;

    // Enqueue stage: entry storage carries data only, no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            op_mem[wptr]   <= amo_op_i;
            addr_mem[wptr] <= paddr_i;
            data_mem[wptr] <= data_i;
            size_mem[wptr] <= data_size_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush_i) begin
            // Only the in-flight head survives a flush.
            if (pop) begin
                rptr  <= next_ptr(rptr);
                wptr  <= next_ptr(rptr);
                count <= '0;
            end else if (state_q == S_ISSUE) begin
                wptr  <= next_ptr(rptr);
                count <= CNT_W'(1);
            end else begin
                wptr  <= rptr;
                count <= '0;
            end
        end else begin
            if (push) wptr <= next_ptr(wptr);
            if (pop)  rptr <= next_ptr(rptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count != '0 && !flush_i) state_d = S_WAIT;
            S_WAIT: begin
                if (flush_i)                   state_d = S_IDLE;
                else if (no_mem_ops_pending_i) state_d = S_ISSUE;
            end
            S_ISSUE: if (amo_ack_i)            state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue     = (state_q == S_ISSUE);
        amo_req_o = issue;
    end

    // Head fields are gated by ISSUE so they read zero outside a request.
    assign amo_op_o   = issue ? op_mem[rptr]   : '0;
    assign amo_addr_o = issue ? addr_mem[rptr] : '0;
    assign amo_data_o = issue ? data_mem[rptr] : '0;
    assign amo_size_o = issue ? size_mem[rptr] : '0;

`ifdef AMO_QUEUE_RESULT_REG_EN
    logic              vld_p0;
    logic [DATA_W-1:0] result_p0;

    // Result stage: one cycle after the ack, value held until the next strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p0    <= 1'b0;
            result_p0 <= '0;
        end else begin
            vld_p0 <= pop;
            if (pop) result_p0 <= fmt_result(amo_result_i, size_mem[rptr]);
        end
    end

    assign result_valid_o = vld_p0;
    assign result_o       = result_p0;
`else
    assign result_valid_o = pop;
    assign result_o       = pop ? fmt_result(amo_result_i, size_mem[rptr]) : '0;
`endif

endmodule

// File: tb/tb_amo_queue.sv
// Directed testbench for amo_queue (DEPTH=3 to exercise non-power-of-2 pointer wrap).
module tb_amo_queue;

    localparam int DEPTH  = 3;
    localparam int PLEN   = 56;
    localparam int DATA_W = 64;
    localparam int OP_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              valid;
    logic              ready;
    logic [OP_W-1:0]   op;
    logic [PLEN-1:0]   paddr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        dsize;
    logic              no_pend;
    logic              req;
    logic [OP_W-1:0]   req_op;
    logic [PLEN-1:0]   req_addr;
    logic [DATA_W-1:0] req_data;
    logic [1:0]        req_size;
    logic              ack;
    logic [DATA_W-1:0] ack_res;
    logic              res_vld;
    logic [DATA_W-1:0] res;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] res_q[$];

    amo_queue #(.DEPTH(DEPTH), .PLEN(PLEN), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(ready),
        .amo_op_i(op), .paddr_i(paddr), .data_i(wdata), .data_size_i(dsize),
        .no_mem_ops_pending_i(no_pend), .amo_req_o(req), .amo_op_o(req_op),
        .amo_addr_o(req_addr), .amo_data_o(req_data), .amo_size_o(req_size),
        .amo_ack_i(ack), .amo_result_i(ack_res), .result_valid_o(res_vld), .result_o(res)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && res_vld) res_q.push_back(res);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [OP_W-1:0] o, input logic [PLEN-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [1:0] s);
        valid = 1'b1; op = o; paddr = a; wdata = d; dsize = s;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_req(input string name, input int max);
        int n;
        n = 0;
        while (!req && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL %s: amo_req_o=%b after %0d cycles, required 1", name, req, n);
        end
    endtask

    task automatic do_ack(input logic [DATA_W-1:0] r);
        ack = 1'b1; ack_res = r;
        tick();
        ack = 1'b0; ack_res = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks += 8;
        if (ready !== 1'b1)   begin errors++; $display("FAIL rst_ready: got %b want 1", ready); end
        if (req !== 1'b0)     begin errors++; $display("FAIL rst_req: got %b want 0", req); end
        if (res_vld !== 1'b0) begin errors++; $display("FAIL rst_res_vld: got %b want 0", res_vld); end
        if (res !== '0)       begin errors++; $display("FAIL rst_res: got %h want 0", res); end
        if (req_op !== '0)    begin errors++; $display("FAIL rst_op: got %h want 0", req_op); end
        if (req_addr !== '0)  begin errors++; $display("FAIL rst_addr: got %h want 0", req_addr); end
        if (req_data !== '0)  begin errors++; $display("FAIL rst_data: got %h want 0", req_data); end
        if (req_size !== '0)  begin errors++; $display("FAIL rst_size: got %h want 0", req_size); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        res_q.delete();
        no_pend = 1'b1;
        push(4'h2, 56'h8000_0010, 64'd5, 2'd3);
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL single_req_n1: got %b want 0", req); end
        tick();
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL single_req_n2: got %b want 0", req); end
        tick();
        checks += 5;
        if (req !== 1'b1)               begin errors++; $display("FAIL single_req_rise: got %b want 1", req); end
        if (req_op !== 4'h2)            begin errors++; $display("FAIL single_op: got %h want 2", req_op); end
        if (req_addr !== 56'h8000_0010) begin errors++; $display("FAIL single_addr: got %h want 80000010", req_addr); end
        if (req_data !== 64'd5)         begin errors++; $display("FAIL single_data: got %h want 5", req_data); end
        if (req_size !== 2'd3)          begin errors++; $display("FAIL single_size: got %h want 3", req_size); end
        tick(); tick();
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL single_req_hold: got %b want 1", req); end
        do_ack(64'h7);
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %b want 0", req); end
        tick(); tick();
        checks += 2;
        if (res_q.size() != 1) begin errors++; $display("FAIL single_strobes: got %0d want 1", res_q.size()); end
        else if (res_q[0] !== 64'h7) begin errors++; $display("FAIL single_result: got %h want 7", res_q[0]); end
        if (req !== 1'b0) begin errors++; $display("FAIL single_no_reissue: got %b want 0", req); end
    endtask

    task automatic test_format();
        logic [1:0]        sz  [5];
        logic [DATA_W-1:0] raw [5];
        logic [DATA_W-1:0] exp [5];
        sz[0] = 2'd3; raw[0] = 64'h0123_4567_89AB_CDEF; exp[0] = 64'h0123_4567_89AB_CDEF;
        sz[1] = 2'd2; raw[1] = 64'h0000_0000_8000_0001; exp[1] = 64'hFFFF_FFFF_8000_0001;
        sz[2] = 2'd2; raw[2] = 64'hFFFF_FFFF_7FFF_FFFF; exp[2] = 64'h0000_0000_7FFF_FFFF;
        sz[3] = 2'd1; raw[3] = 64'h1234_5678_9ABC_DEF0; exp[3] = 64'h0000_0000_0000_DEF0;
        sz[4] = 2'd0; raw[4] = 64'h1234_5678_9ABC_DEF0; exp[4] = 64'h0000_0000_0000_00F0;
        no_pend = 1'b1;
        for (int i = 0; i < 5; i++) begin
            res_q.delete();
            push(4'h1, 56'h1000 + 56'(i * 8), 64'(i), sz[i]);
            wait_req("fmt_req", 10);
            do_ack(raw[i]);
            tick(); tick();
            checks++;
            if (res_q.size() != 1) begin
                errors++; $display("FAIL fmt_strobe[%0d]: got %0d want 1", i, res_q.size());
            end else if (res_q[0] !== exp[i]) begin
                errors++; $display("FAIL fmt_result[%0d]: got %h want %h", i, res_q[0], exp[i]);
            end
        end
    endtask

    task automatic test_drain_gating();
        logic seen;
        res_q.delete();
        no_pend = 1'b0;
        seen = 1'b0;
        push(4'h3, 56'h2000, 64'd9, 2'd3);
        for (int i = 0; i < 10; i++) begin
            if (req) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL drain_gated: req seen=%b want 0", seen); end
        no_pend = 1'b1;
        tick();
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL drain_release: got %b want 1", req); end
        no_pend = 1'b0;
        tick();
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL drain_no_retract: got %b want 1", req); end
        do_ack(64'h99);
        tick(); tick();
    endtask

    task automatic test_full_wrap();
        logic [PLEN-1:0] exp_addr [5];
        exp_addr[0] = 56'hA00; exp_addr[1] = 56'hB00; exp_addr[2] = 56'hC00;
        exp_addr[3] = 56'hD00; exp_addr[4] = 56'hE00;
        res_q.delete();
        no_pend = 1'b0;
        push(4'h0, exp_addr[0], 64'd0, 2'd3);
        push(4'h0, exp_addr[1], 64'd1, 2'd3);
        push(4'h0, exp_addr[2], 64'd2, 2'd3);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", ready); end
        push(4'h0, 56'hDEAD, 64'hBAD, 2'd3);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL full_drop_ready: got %b want 0", ready); end
        no_pend = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_req("wrap_req", 10);
            checks++;
            if (req_addr !== exp_addr[k]) begin
                errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, req_addr, exp_addr[k]);
            end
            do_ack(64'h100 + 64'(k));
            if (k == 0) begin
                checks++;
                if (ready !== 1'b1) begin errors++; $display("FAIL wrap_ready_on_ack: got %b want 1", ready); end
                push(4'h0, exp_addr[3], 64'd3, 2'd3);
            end
            if (k == 1) push(4'h0, exp_addr[4], 64'd4, 2'd3);
        end
        tick(); tick(); tick();
        checks += 2;
        if (req !== 1'b0)      begin errors++; $display("FAIL wrap_empty_req: got %b want 0", req); end
        if (res_q.size() != 5) begin errors++; $display("FAIL wrap_strobes: got %0d want 5", res_q.size()); end
        else if (res_q[4] !== 64'h104) begin errors++; $display("FAIL wrap_last_result: got %h want 104", res_q[4]); end
    endtask

    task automatic test_flush();
        logic seen;
        res_q.delete();
        no_pend = 1'b1;
        push(4'h5, 56'hF00, 64'd1, 2'd3);
        push(4'h5, 56'hF08, 64'd2, 2'd3);
        wait_req("flush_req", 10);
        flush = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", ready); end
        tick();
        flush = 1'b0;
        checks += 2;
        if (req !== 1'b1)        begin errors++; $display("FAIL flush_inflight: got %b want 1", req); end
        if (req_addr !== 56'hF00) begin errors++; $display("FAIL flush_head: got %h want f00", req_addr); end
        do_ack(64'h55);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (req) seen = 1'b1;
            tick();
        end
        checks += 3;
        if (seen !== 1'b0)     begin errors++; $display("FAIL flush_no_reissue: req seen=%b want 0", seen); end
        if (ready !== 1'b1)    begin errors++; $display("FAIL flush_ready_after: got %b want 1", ready); end
        if (res_q.size() != 1) begin errors++; $display("FAIL flush_strobes: got %0d want 1", res_q.size()); end
        else if (res_q[0] !== 64'h55) begin errors++; $display("FAIL flush_result: got %h want 55", res_q[0]); end
    endtask

    task automatic test_ack_outside();
        res_q.delete();
        do_ack(64'h77);
        tick();
        checks++;
        if (res_q.size() != 0) begin errors++; $display("FAIL stray_ack: strobes %0d want 0", res_q.size()); end
    endtask

    task automatic test_reset_mid_issue();
        logic seen;
        no_pend = 1'b1;
        push(4'h7, 56'h3000, 64'd3, 2'd3);
        wait_req("rst_mid_req", 10);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req !== 1'b0) begin errors++; $display("FAIL rst_mid_req_async: got %b want 0", req); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (req) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_req: seen=%b want 0", seen); end
    endtask

    initial begin
        flush = 1'b0; valid = 1'b0; op = '0; paddr = '0; wdata = '0; dsize = '0;
        no_pend = 1'b0; ack = 1'b0; ack_res = '0;
        test_reset();
        test_single();
        test_format();
        test_drain_gating();
        test_full_wrap();
        test_flush();
        test_ack_outside();
        test_reset_mid_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
